// File: rtl/channel_serializer.sv
// Purpose: serializes one packed CHANNELS*D_WIDTH pixel into one D_WIDTH channel value per handshake; RELU_SERIALIZE_EN zeroes negative channels.
// Latency: 1 cycle from pixel accept to channel 0; back-to-back pixels stream with no bubble.
// Backpressure: out_ready low freezes the current channel; a new pixel is taken only when the last channel leaves.
module channel_serializer #(
    parameter int D_WIDTH  = 8,
    parameter int CHANNELS = 3,
    parameter int CH_W     = 2,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [D_WIDTH*CHANNELS-1:0]  in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [D_WIDTH-1:0]           out_data,
    output logic [CH_W-1:0]              out_channel,
    output logic                         out_pixel_last,
    output logic                         out_frame_last,
    output logic [CNT_W-1:0]             pixel_count
);

    localparam logic [0:0]      S_IDLE  = 1'b0;
    localparam logic [0:0]      S_SHIFT = 1'b1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
    localparam int              N_SLOTS = 1 << CH_W;

    logic [0:0]                  r_state;
    logic [D_WIDTH*CHANNELS-1:0] r_hold;
    logic                        r_last;
    logic [CH_W-1:0]             r_ch;
    logic [CNT_W-1:0]            r_cnt;

    logic                        w_at_last;
    logic                        w_done;
    logic [D_WIDTH-1:0]          w_sel;
    logic [D_WIDTH-1:0]          w_chan [0:N_SLOTS-1];

    // Channel slots padded to a power of two so the index never leaves the array.
    genvar g;
    generate
        for (g = 0; g < N_SLOTS; g++) begin : g_slot
            if (g < CHANNELS) begin : g_real
                assign w_chan[g] = r_hold[g*D_WIDTH +: D_WIDTH];
            end else begin : g_pad
                assign w_chan[g] = '0;
            end
        end
    endgenerate

    assign w_sel     = w_chan[r_ch];
    assign w_at_last = (r_ch == LAST_CH);
    assign w_done    = (r_state == S_SHIFT) && out_ready && w_at_last;

    // Handshake flags; upstream is only accepted while idle or as the last channel leaves.
    always_comb begin
        out_valid      = (r_state == S_SHIFT);
        in_ready       = (r_state == S_IDLE) || w_done;
        out_channel    = r_ch;
        out_pixel_last = out_valid && w_at_last;
        out_frame_last = out_pixel_last && r_last;
        pixel_count    = r_cnt;
    end

    // Read-out mux, optionally clamping negative channels to zero.
    always_comb begin
`ifdef RELU_SERIALIZE_EN
        out_data = w_sel[D_WIDTH-1] ? '0 : w_sel;
`else
        out_data = w_sel;
`endif
    end

    // Pixel holding register, channel index and IDLE/SHIFT sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_last  <= 1'b0;
            r_ch    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_hold  <= in_data;
                        r_last  <= in_last;
                        r_ch    <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (!w_at_last) begin
                            r_ch <= r_ch + CH_W'(1);
                        end else if (in_valid) begin
                            // Next pixel replaces the finished one with no idle cycle.
                            r_hold <= in_data;
                            r_last <= in_last;
                            r_ch   <= '0;
                        end else begin
                            r_ch    <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Completed-pixel counter, cleared after the pixel that ends a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_cnt <= r_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
